// File: rtl/tank_pkg.sv
// Shared types and constants for the tank game round controller.
package tank_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ROUND_INIT = 3'd1,
    COUNTDOWN  = 3'd2,
    PLAY       = 3'd3,
    RESULT     = 3'd4,
    MATCH_OVER = 3'd5
  } game_state_t;

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_P1   = 2'd1;
  localparam logic [1:0] WIN_P2   = 2'd2;
  localparam logic [1:0] WIN_DRAW = 2'd3;

  // Saturating score increment; never steps past the match limit.
  function automatic logic [3:0] sat_inc(input logic [3:0] value, input logic [3:0] limit);
    if (value < limit) begin
      return value + 4'd1;
    end else begin
      return value;
    end
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Loadable frame_tick down-counter; expired flags the tick that consumes the final frame.
module frame_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic [W-1:0] value,
  output logic         expired
);

  logic [W-1:0] count_d;
  logic [W-1:0] count_q;

  // Load wins over a coincident tick, so the entry-cycle tick is not counted.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (tick && (count_q != {W{1'b0}})) begin
      count_d = count_q - {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign value   = count_q;
  assign expired = tick && (count_q == {{(W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/round_controller.sv
// Match/round sequencing FSM: start, countdown, play, result hold and match over.
module round_controller
  import tank_pkg::*;
#(
  parameter int STEP_FRAMES   = 60,
  parameter int RESULT_FRAMES = 120,
  parameter int WIN_SCORE     = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       hit_player,
  input  logic       hit_opponent,
  output logic       game_on,
  output logic       round_reset,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [1:0] countdown_digit,
  output logic [1:0] winner,
  output logic [2:0] state
);

  localparam int MAX_FRAMES = (STEP_FRAMES > RESULT_FRAMES) ? STEP_FRAMES : RESULT_FRAMES;
  localparam int CNT_W      = $clog2(MAX_FRAMES + 1);
  localparam logic [CNT_W-1:0] STEP_LOAD   = CNT_W'(STEP_FRAMES);
  localparam logic [CNT_W-1:0] RESULT_LOAD = CNT_W'(RESULT_FRAMES);
  localparam logic [3:0]       WIN_LIMIT   = 4'(WIN_SCORE);

  game_state_t state_d, state_q;
  logic [3:0] score1_d, score1_q, score2_d, score2_q;
  logic [1:0] winner_d, winner_q, digit_d, digit_q;
  logic       game_on_d, game_on_q, round_reset_d, round_reset_q;
  // start_arm holds "start was low last cycle"; cleared by reset so a held button gives no edge.
  logic       start_arm_d, start_arm_q;
  logic       start_edge;
  logic       timer_load;
  logic [CNT_W-1:0] timer_load_value, timer_value;
  logic       timer_expired;

  assign start_edge = start && start_arm_q;

  frame_timer #(.W(CNT_W)) u_frame_timer (
    .clk        (clk),
    .reset      (reset),
    .tick       (frame_tick),
    .load       (timer_load),
    .load_value (timer_load_value),
    .value      (timer_value),
    .expired    (timer_expired)
  );

  // Next-state, score and display logic.
  always_comb begin
    state_d          = state_q;
    score1_d         = score1_q;
    score2_d         = score2_q;
    winner_d         = winner_q;
    digit_d          = digit_q;
    start_arm_d      = ~start;
    timer_load       = 1'b0;
    timer_load_value = {CNT_W{1'b0}};
    case (state_q)
      IDLE: begin
        if (start_edge) begin
          score1_d = 4'd0;
          score2_d = 4'd0;
          winner_d = WIN_NONE;
          state_d  = ROUND_INIT;
        end else begin
          state_d = IDLE;
        end
      end
      ROUND_INIT: begin
        state_d          = COUNTDOWN;
        digit_d          = 2'd3;
        timer_load       = 1'b1;
        timer_load_value = STEP_LOAD;
      end
      COUNTDOWN: begin
        if (timer_expired && (digit_q == 2'd1)) begin
          state_d = PLAY;
          digit_d = 2'd0;
        end else if (timer_expired) begin
          digit_d          = digit_q - 2'd1;
          timer_load       = 1'b1;
          timer_load_value = STEP_LOAD;
        end else begin
          state_d = COUNTDOWN;
        end
      end
      PLAY: begin
        if (hit_player || hit_opponent) begin
          state_d          = RESULT;
          timer_load       = 1'b1;
          timer_load_value = RESULT_LOAD;
          if (hit_player && hit_opponent) begin
            winner_d = WIN_DRAW;
          end else if (hit_opponent) begin
            score1_d = sat_inc(score1_q, WIN_LIMIT);
            winner_d = WIN_P1;
          end else begin
            score2_d = sat_inc(score2_q, WIN_LIMIT);
            winner_d = WIN_P2;
          end
        end else begin
          state_d = PLAY;
        end
      end
      RESULT: begin
        if (timer_expired && ((score1_q == WIN_LIMIT) || (score2_q == WIN_LIMIT))) begin
          state_d  = MATCH_OVER;
          winner_d = (score1_q > score2_q) ? WIN_P1 : WIN_P2;
        end else if (timer_expired) begin
          state_d = ROUND_INIT;
        end else begin
          state_d = RESULT;
        end
      end
      MATCH_OVER: begin
        if (start_edge) begin
          state_d = IDLE;
        end else begin
          state_d = MATCH_OVER;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    game_on_d     = (state_d == PLAY);
    round_reset_d = (state_d == ROUND_INIT);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      score1_q      <= 4'd0;
      score2_q      <= 4'd0;
      winner_q      <= WIN_NONE;
      digit_q       <= 2'd0;
      game_on_q     <= 1'b0;
      round_reset_q <= 1'b0;
      start_arm_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      score1_q      <= score1_d;
      score2_q      <= score2_d;
      winner_q      <= winner_d;
      digit_q       <= digit_d;
      game_on_q     <= game_on_d;
      round_reset_q <= round_reset_d;
      start_arm_q   <= start_arm_d;
    end
  end

  assign game_on         = game_on_q;
  assign round_reset     = round_reset_q;
  assign score1          = score1_q;
  assign score2          = score2_q;
  assign countdown_digit = digit_q;
  assign winner          = winner_q;
  assign state           = state_q;

endmodule

// File: tb/tb_round_controller.sv
// Directed self-checking bench for round_controller (STEP=2, RESULT=3, WIN=2).
module tb_round_controller;

  logic       clk = 1'b0;
  logic       reset, frame_tick, start, hit_player, hit_opponent;
  logic       game_on, round_reset;
  logic [3:0] score1, score2;
  logic [1:0] countdown_digit, winner;
  logic [2:0] state;
  int checks   = 0;
  int failures = 0;

  round_controller #(.STEP_FRAMES(2), .RESULT_FRAMES(3), .WIN_SCORE(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .frame_tick      (frame_tick),
    .start           (start),
    .hit_player      (hit_player),
    .hit_opponent    (hit_opponent),
    .game_on         (game_on),
    .round_reset     (round_reset),
    .score1          (score1),
    .score2          (score2),
    .countdown_digit (countdown_digit),
    .winner          (winner),
    .state           (state)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Gap cycle after entering COUNTDOWN, then six ticks to reach PLAY.
  task automatic run_countdown();
    cyc();
    repeat (6) tick();
  endtask

  initial begin
    reset = 1'b1; frame_tick = 1'b0; start = 1'b0; hit_player = 1'b0; hit_opponent = 1'b0;
    cyc(); cyc();
    chk("rst_state", 8'(state), 8'd0);
    chk("rst_game_on", 8'(game_on), 8'd0);
    chk("rst_round_reset", 8'(round_reset), 8'd0);
    chk("rst_scores", 8'({score1, score2}), 8'd0);
    chk("rst_digit_winner", 8'({countdown_digit, winner}), 8'd0);
    reset = 1'b0;
    cyc();

    start = 1'b1; cyc();
    chk("init_state", 8'(state), 8'd1);
    chk("init_pulse", 8'(round_reset), 8'd1);
    cyc();
    chk("cd_state", 8'(state), 8'd2);
    chk("cd_pulse_gone", 8'(round_reset), 8'd0);
    chk("cd_digit3", 8'(countdown_digit), 8'd3);
    hit_opponent = 1'b1; cyc(); hit_opponent = 1'b0;
    chk("cd_hit_score", 8'(score1), 8'd0);
    chk("cd_hit_state", 8'(state), 8'd2);
    start = 1'b0;
    tick();
    chk("cd_tick1_digit", 8'(countdown_digit), 8'd3);
    tick();
    chk("cd_tick2_digit", 8'(countdown_digit), 8'd2);
    tick(); tick();
    chk("cd_tick4_digit", 8'(countdown_digit), 8'd1);
    tick();
    chk("cd_tick5_state", 8'(state), 8'd2);
    chk("cd_tick5_game_on", 8'(game_on), 8'd0);
    tick();
    chk("play_state", 8'(state), 8'd3);
    chk("play_game_on", 8'(game_on), 8'd1);
    chk("play_digit0", 8'(countdown_digit), 8'd0);

    cyc();
    hit_opponent = 1'b1; cyc(); hit_opponent = 1'b0;
    chk("p1win_game_on", 8'(game_on), 8'd0);
    chk("p1win_score1", 8'(score1), 8'd1);
    chk("p1win_winner", 8'(winner), 8'd1);
    chk("p1win_state", 8'(state), 8'd4);
    hit_player = 1'b1; cyc(); hit_player = 1'b0;
    chk("res_hit_score2", 8'(score2), 8'd0);
    tick(); tick();
    chk("res_hold", 8'(state), 8'd4);
    tick();
    chk("res_exp_state", 8'(state), 8'd1);
    chk("res_exp_pulse", 8'(round_reset), 8'd1);

    cyc(); run_countdown();
    chk("r2_play", 8'(state), 8'd3);
    hit_player = 1'b1; hit_opponent = 1'b1; cyc(); hit_player = 1'b0; hit_opponent = 1'b0;
    chk("draw_winner", 8'(winner), 8'd3);
    chk("draw_scores", 8'({score1, score2}), 8'h10);
    chk("draw_state", 8'(state), 8'd4);
    repeat (3) tick();
    chk("draw_next_round", 8'(state), 8'd1);

    cyc(); run_countdown();
    hit_player = 1'b1; cyc(); hit_player = 1'b0;
    chk("p2win1_score2", 8'(score2), 8'd1);
    chk("p2win1_winner", 8'(winner), 8'd2);
    repeat (3) tick();
    chk("p2win1_next_round", 8'(state), 8'd1);

    cyc(); run_countdown();
    hit_player = 1'b1; cyc(); hit_player = 1'b0;
    chk("p2win2_score2", 8'(score2), 8'd2);
    repeat (3) tick();
    chk("mo_state", 8'(state), 8'd5);
    chk("mo_winner", 8'(winner), 8'd2);
    chk("mo_scores", 8'({score1, score2}), 8'h12);
    hit_opponent = 1'b1; cyc(); hit_opponent = 1'b0;
    chk("mo_hit_ignored", 8'({score1, score2}), 8'h12);
    chk("mo_hit_state", 8'(state), 8'd5);
    start = 1'b1; cyc();
    chk("mo_to_idle", 8'(state), 8'd0);
    chk("idle_holds_scores", 8'({score1, score2}), 8'h12);
    chk("idle_holds_winner", 8'(winner), 8'd2);
    start = 1'b0; cyc();
    start = 1'b1; cyc();
    chk("restart_state", 8'(state), 8'd1);
    chk("restart_clear", 8'({score1, score2}), 8'h00);
    chk("restart_winner", 8'(winner), 8'd0);

    cyc(); cyc(); tick();
    chk("pre_abort_state", 8'(state), 8'd2);
    reset = 1'b1; cyc();
    chk("abort_state", 8'(state), 8'd0);
    chk("abort_outputs", 8'({game_on, round_reset, countdown_digit, winner}), 8'd0);
    chk("abort_scores", 8'({score1, score2}), 8'd0);
    reset = 1'b0; cyc(); cyc();
    chk("held_start_no_edge", 8'(state), 8'd0);
    chk("held_start_no_pulse", 8'(round_reset), 8'd0);
    start = 1'b0; cyc();
    start = 1'b1; cyc();
    chk("toggle_start", 8'(state), 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/round_controller.md
ROUND_CONTROLLER -- requirements
Module: round_controller

Interface
REQ-001 SHALL have parameter STEP_FRAMES, default 60: frame ticks per countdown digit.
REQ-002 SHALL have parameter RESULT_FRAMES, default 120: frame ticks the result screen is held.
REQ-003 SHALL have parameter WIN_SCORE, default 3, legal range 1..15: round wins needed to take the match.
REQ-004 SHALL have port clk, input, 1: sole clock; all logic on the rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high.
REQ-006 SHALL have port frame_tick, input, 1: one-cycle pulse per video frame.
REQ-007 SHALL have port start, input, 1: level from the start button, already debounced.
REQ-008 SHALL have port hit_player, input, 1: player tank hit this cycle.
REQ-009 SHALL have port hit_opponent, input, 1: opponent tank hit this cycle.
REQ-010 SHALL have port game_on, output, 1: tanks and bullets may move.
REQ-011 SHALL have port round_reset, output, 1: one-cycle pulse that reinitialises tanks and bullets.
REQ-012 SHALL have port score1 and port score2, output, 4 each: round wins for player 1 and player 2.
REQ-013 SHALL have port countdown_digit, output, 2: digit to display (3, 2, 1), or 0 outside COUNTDOWN.
REQ-014 SHALL have port winner, output, 2: 0 none, 1 player 1, 2 player 2, 3 draw; shows the last round result, or the match winner in MATCH_OVER.
REQ-015 SHALL have port state, output, 3: current FSM state encoding, for debug and the HUD.

Function
REQ-016 SHALL implement the states IDLE, ROUND_INIT, COUNTDOWN, PLAY, RESULT, MATCH_OVER.
REQ-017 SHALL detect a start rising edge from a registered copy of start; only the edge triggers a transition, and holding start SHALL NOT retrigger.
REQ-018 IDLE: on a start edge, SHALL clear score1, score2 and winner, then go to ROUND_INIT.
REQ-019 ROUND_INIT SHALL last exactly one cycle, with round_reset=1 in that cycle only; it then goes to COUNTDOWN with countdown_digit=3 and the frame counter set to STEP_FRAMES.
REQ-020 COUNTDOWN SHALL decrement the frame counter on each frame_tick.
REQ-021 COUNTDOWN: when a frame_tick arrives with counter=1, SHALL reload STEP_FRAMES and decrement the digit; when the digit would leave 1, SHALL go to PLAY with the digit at 0.
REQ-022 COUNTDOWN SHALL therefore last exactly 3*STEP_FRAMES frame ticks.
REQ-023 PLAY: game_on=1 in PLAY only; game_on SHALL be registered and fall in the first cycle after a hit is sampled.
REQ-024 PLAY, hit_opponent only: SHALL increment score1, set winner=1, and go to RESULT.
REQ-025 PLAY, hit_player only: SHALL increment score2, set winner=2, and go to RESULT.
REQ-026 PLAY, both hits in the same cycle: SHALL count a draw, with no score change, winner=3, and go to RESULT.
REQ-027 Score updates SHALL take effect on the same edge as the state change.
REQ-028 Hit inputs SHALL be ignored in every state other than PLAY.
REQ-029 RESULT SHALL load RESULT_FRAMES and hold for RESULT_FRAMES frame ticks.
REQ-030 RESULT, on expiry: if score1==WIN_SCORE or score2==WIN_SCORE, SHALL go to MATCH_OVER and set winner to the leading player; otherwise SHALL go to ROUND_INIT.
REQ-031 Scores SHALL never exceed WIN_SCORE; an increment at WIN_SCORE is impossible by construction, and the RTL SHALL saturate anyway.
REQ-032 MATCH_OVER: a start edge SHALL go to IDLE; scores and winner SHALL hold until IDLE clears them on the next start edge.
REQ-033 frame_tick arriving in the same cycle as a state entry SHALL be ignored for that state; counting starts on the next tick.
REQ-034 All outputs SHALL be registered.

Reset
REQ-035 On reset: state=IDLE, game_on=0, round_reset=0, score1=score2=0, winner=0, countdown_digit=0, counters=0, start edge register=0.
REQ-036 Reset asserted mid-round SHALL abort immediately, with no round_reset pulse emitted.
REQ-037 The start edge register SHALL be cleared by reset, so a start level held through reset produces no edge.

Structure
REQ-038 SHALL use package tank_pkg, which holds the game_state_t enum and the winner code constants (WIN_NONE, WIN_P1, WIN_P2, WIN_DRAW).
REQ-039 SHALL use one sub-module frame_timer: a loadable frame_tick down-counter with load, value and expired outputs, shared by COUNTDOWN and RESULT.

Verification
REQ-040 Bench parameters SHALL be STEP_FRAMES=2, RESULT_FRAMES=3, WIN_SCORE=2.
REQ-041 Start edge from IDLE -> exactly one round_reset cycle, then countdown_digit goes 3,2,1 over 6 ticks, then game_on=1.
REQ-042 hit_opponent pulse in PLAY -> next cycle game_on=0, score1=1, winner=1, state=RESULT; after 3 ticks, ROUND_INIT with round_reset pulse.
REQ-043 hit_player and hit_opponent in the same cycle -> winner=3, scores unchanged, new round follows.
REQ-044 Two player-2 round wins -> after RESULT, state=MATCH_OVER, winner=2, score2=2; further hits ignored; start edge -> IDLE; next start edge -> scores 0.
REQ-045 Reset asserted during COUNTDOWN -> next cycle IDLE with all outputs 0; start held high through reset release -> stays IDLE until it toggles.
REQ-046 Hit pulses during COUNTDOWN or RESULT -> no score or state change.
